trace_arb: RTL and testbench
============================

# trace_arb

Shares one trace sink (Spike-format log writer) among CORES harts. Each hart pushes retired-instruction commit records into its own small FIFO. A round-robin scheduler drains the FIFOs one record per cycle onto a single valid/ready output tagged with the hart index. Sits between the per-hart commit monitors and the trace formatter/file writer in the RISCOF bench.

## Interface
- CORES, 2: number of harts/requesters (1..16).
- DEPTH, 4: per-hart FIFO depth, power of two, ≥2.
- XLEN, 32: data/address width of record fields.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_vld  input  CORES  per-hart commit record valid.
- in_rec  input  CORES×trace_rec_t  per-hart record: ifu_adr, ifu_ins, wbu_ena, wbu_idx[5], wbu_dat, lsu_ena, lsu_wen, lsu_ren, lsu_adr, lsu_siz[2], lsu_wdt.
- in_rdy  output  CORES  per-hart FIFO not full.
- out_vld  output  1  record available.
- out_rec  output  trace_rec_t  selected record.
- out_core  output  $clog2(CORES) (min 1)  hart index of out_rec.
- out_rdy  input  1  sink accepts.
- cnt  output  CORES×64  per-hart transferred-record counters (only with TRACE_ARB_STAT_EN).

## Operation
- Push: in_vld[i] & in_rdy[i] writes in_rec[i] at tail of FIFO i. in_rdy[i] = !full[i]; no push on full even if the same FIFO pops that cycle.
- Requests: req[i] = !empty[i].
- Arbiter states: IDLE (no req, out_vld=0) and GRANT (locked on hart g, out_vld=1).
- IDLE→GRANT: any req; g = first requesting index at or after pointer ptr, wrapping modulo CORES.
- GRANT, out_rdy=1: pop FIFO g. ptr←(g+1) mod CORES. Re-arbitrate next cycle: GRANT if any req remains, else IDLE.
- GRANT, out_rdy=0: g, out_rec and out_core held stable. out_vld never drops without transfer. New requests do not preempt.
- Per-hart order preserved. Cross-hart order is round-robin only, not retire-time order.
- Simultaneous push and pop on the same FIFO (not full): both take effect, occupancy unchanged.
- Reset mid-operation: all FIFOs emptied, pending records discarded, ptr=0, state IDLE.
- Reset values: out_vld=0, out_core=0, out_rec=0, in_rdy=all ones, cnt=0, ptr=0.

## Timing
- Push to out_vld: 1 cycle minimum (registered FIFO, no bypass).
- Throughput: one record per cycle total when out_rdy held high. Back-to-back grants of different harts need no idle cycle.
- With all harts continuously requesting, each hart receives a grant at least once every CORES transfers.
- Pointers: log2(DEPTH)+1 bits, so full and empty are distinguished at wrap-around.
- out_rec and out_core are muxed from registered FIFO heads and the registered grant. No combinational path from in_* to out_*.
- in_rdy depends only on registered occupancy.

## Configuration
- TRACE_ARB_STAT_EN defined: port cnt present. cnt[i] increments on every out transfer with out_core=i and wraps at 2^64.
- Not defined: cnt port and counters absent; all other behaviour identical.

## Structure
- trace_pkg holds: trace_rec_t packed struct (field order as listed under in_rec), XLEN constant, and trace_arb_state_t enum {IDLE, GRANT}.
- One sub-module, trace_fifo: synchronous single-clock FIFO with asynchronous active-low reset. Parameters DEPTH and type/width of trace_rec_t. Ports: push, pop, wdata, rdata, full, empty. Instantiated CORES times.

## Test plan
- Single hart: push records with ifu_adr 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, out_rdy=1 -> same three records on out in order, out_core=0, first out_vld one cycle after first push.
- Two harts, continuous push, out_rdy=1 -> out_core alternates 0,1,0,1. No bubble after the first output.
- Backpressure: out_vld=1 with out_rdy=0 for 5 cycles while hart 1 pushes -> out_rec/out_core stable for the 5 cycles. Grant stays on original hart until out_rdy=1.
- Full: DEPTH=4, hart 0 pushes 6 records with out_rdy=0 -> in_rdy[0] low after the 4th push. Only records 1–4 are ever output. Simultaneous pop and push at full is refused that cycle.
- Reset mid-operation: assert rst low with 3 records queued -> out_vld=0 and in_rdy all ones immediately (asynchronous). After release, output follows only new pushes.
- TRACE_ARB_STAT_EN: transfer 7 records from hart 1 and 3 from hart 0 -> cnt[1]=7, cnt[0]=3. Build without the macro compiles with the cnt port absent.

Source files
------------

// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types for the commit-trace arbiter.
//   XLEN               : width of address/data fields in a commit record
//   trace_rec_t        : one retired-instruction commit record (packed)
//   trace_arb_state_t  : arbiter grant state
// -----------------------------------------------------------------------------
package trace_pkg;

    localparam int XLEN = 32;

    // IDLE : free to arbitrate among the current requests
    // GRANT: a record was presented but not taken, so the grant stays locked
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } trace_arb_state_t;

    typedef struct packed {
        logic [XLEN-1:0] ifu_adr;
        logic [31:0]     ifu_ins;
        logic            wbu_ena;
        logic [4:0]      wbu_idx;
        logic [XLEN-1:0] wbu_dat;
        logic            lsu_ena;
        logic            lsu_wen;
        logic            lsu_ren;
        logic [XLEN-1:0] lsu_adr;
        logic [1:0]      lsu_siz;
        logic [XLEN-1:0] lsu_wdt;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Single-clock FIFO holding commit records for one hart. Read data is the
// registered head entry (no write-through bypass).
// Parameters: DEPTH (power of two, >= 2), WIDTH (record width in bits)
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset, empties the FIFO
//   push   in   write wdata at the tail (ignored while full, even if popping)
//   pop    in   drop the head entry (ignored while empty)
//   wdata  in   record to write
//   rdata  out  head entry
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
// -----------------------------------------------------------------------------
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(trace_rec_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign rdata = mem_r[rd_ptr_r[AW-1:0]];

    // Qualify requests against the registered occupancy flags.
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
    end

    // Read/write pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/trace_arb.sv
// -----------------------------------------------------------------------------
// trace_arb
// Shares one trace sink among CORES harts. Each hart pushes commit records
// into its own trace_fifo; a round-robin scheduler drains one record per
// cycle onto a single valid/ready output tagged with the hart index.
// Optional feature macro: TRACE_ARB_STAT_EN adds per-hart 64-bit transfer
// counters on port cnt.
// Parameters: CORES (1..16), DEPTH (power of two, >= 2)
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-low reset
//   in_vld    in   per-hart record valid
//   in_rec    in   per-hart commit record
//   in_rdy    out  per-hart FIFO not full
//   out_vld   out  record available
//   out_rec   out  selected record (zero while out_vld is low)
//   out_core  out  hart index of out_rec
//   out_rdy   in   sink accepts
//   cnt       out  per-hart transferred-record counters (TRACE_ARB_STAT_EN)
// -----------------------------------------------------------------------------
module trace_arb
    import trace_pkg::*;
#(
    parameter  int CORES = 2,
    parameter  int DEPTH = 4,
    localparam int CW    = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic       [CORES-1:0] in_vld,
    input  trace_rec_t [CORES-1:0] in_rec,
    output logic       [CORES-1:0] in_rdy,
    output logic                   out_vld,
    output trace_rec_t             out_rec,
    output logic       [CW-1:0]    out_core,
    input  logic                   out_rdy
`ifdef TRACE_ARB_STAT_EN
    ,
    output logic [CORES-1:0][63:0] cnt
`endif
);

    localparam int RW = $bits(trace_rec_t);

    logic [CORES-1:0]         full_s;
    logic [CORES-1:0]         empty_s;
    logic [CORES-1:0]         push_s;
    logic [CORES-1:0]         pop_s;
    logic [CORES-1:0][RW-1:0] head_s;

    trace_arb_state_t state_r;
    trace_arb_state_t state_s;
    logic [CW-1:0]    grant_r;
    logic [CW-1:0]    grant_s;
    logic [CW-1:0]    ptr_r;
    logic [CW-1:0]    ptr_s;
    logic             xfer_s;

    // First requesting index at or after ptr, wrapping modulo CORES.
    function automatic logic [CW-1:0] rr_pick(input logic [CORES-1:0] req,
                                               input logic [CW-1:0]    ptr);
        logic [CW-1:0] sel;
        logic          found;
        int            idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < CORES; k++) begin
            idx = (int'(ptr) + k) % CORES;
            if (!found && req[idx]) begin
                sel   = CW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    for (genvar i = 0; i < CORES; i++) begin : g_fifo
        trace_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (RW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_s[i]),
            .pop   (pop_s[i]),
            .wdata (in_rec[i]),
            .rdata (head_s[i]),
            .full  (full_s[i]),
            .empty (empty_s[i])
        );
    end

    // Push side: readiness comes only from registered occupancy.
    always_comb begin
        in_rdy = ~full_s;
        push_s = in_vld & ~full_s;
    end

    // Grant selection, output valid and next-state logic.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        ptr_s   = ptr_r;
        out_vld = 1'b0;
        xfer_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (|(~empty_s)) begin
                    grant_s = rr_pick(~empty_s, ptr_r);
                    out_vld = 1'b1;
                end else begin
                    grant_s = grant_r;
                    out_vld = 1'b0;
                end
            end
            GRANT: begin
                // Locked: later requests never preempt a presented record.
                grant_s = grant_r;
                out_vld = 1'b1;
            end
            default: begin
                grant_s = grant_r;
                out_vld = 1'b0;
            end
        endcase
        xfer_s = out_vld & out_rdy;
        if (xfer_s) begin
            ptr_s   = (grant_s == CW'(CORES - 1)) ? '0 : grant_s + 1'b1;
            state_s = IDLE;
        end else if (out_vld) begin
            state_s = GRANT;
        end else begin
            state_s = IDLE;
        end
    end

    // Pop the granted FIFO on a transfer.
    always_comb begin
        pop_s = '0;
        if (xfer_s) begin
            pop_s[grant_s] = 1'b1;
        end else begin
            pop_s = '0;
        end
    end

    // Output record is the registered head of the granted FIFO.
    always_comb begin
        out_core = grant_s;
        if (out_vld) begin
            out_rec = trace_rec_t'(head_s[grant_s]);
        end else begin
            out_rec = '0;
        end
    end

    // Arbiter state, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            grant_r <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            ptr_r   <= ptr_s;
        end
    end

`ifdef TRACE_ARB_STAT_EN
    logic [CORES-1:0][63:0] cnt_r;

    // Per-hart transfer counters, wrapping at 2^64.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else begin
            for (int i = 0; i < CORES; i++) begin
                if (pop_s[i]) begin
                    cnt_r[i] <= cnt_r[i] + 64'd1;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    assign cnt = cnt_r;
`endif

endmodule

// File: tb/tb_trace_arb.sv
// -----------------------------------------------------------------------------
// tb_trace_arb
// Self-checking bench for trace_arb (CORES=2, DEPTH=4). A queue-based
// reference model tracks per-hart FIFO contents, the round-robin pointer and
// the held grant; directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_trace_arb;
    import trace_pkg::*;

    localparam int CORES = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 1;

    logic                   clk;
    logic                   rst;
    logic       [CORES-1:0] in_vld;
    trace_rec_t [CORES-1:0] in_rec;
    logic       [CORES-1:0] in_rdy;
    logic                   out_vld;
    trace_rec_t             out_rec;
    logic       [CW-1:0]    out_core;
    logic                   out_rdy;
`ifdef TRACE_ARB_STAT_EN
    logic [CORES-1:0][63:0] cnt;
`endif

    trace_arb #(
        .CORES (CORES),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rec   (in_rec),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_rec  (out_rec),
        .out_core (out_core),
        .out_rdy  (out_rdy)
`ifdef TRACE_ARB_STAT_EN
        ,
        .cnt      (cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    trace_rec_t      q_m [CORES][$];
    int              ptr_m;
    bit              held_m;
    int              held_core_m;
    longint unsigned cnt_m [CORES];
    // DUT-observed transfers
    logic [31:0]     log_adr [$];
    int              log_core [$];

    int total;
    int bad;

    task automatic check_eq(input string tag, input logic [255:0] got,
                            input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic trace_rec_t rnd_rec();
        trace_rec_t r;
        r.ifu_adr = $urandom;
        r.ifu_ins = $urandom;
        r.wbu_ena = 1'($urandom);
        r.wbu_idx = 5'($urandom);
        r.wbu_dat = $urandom;
        r.lsu_ena = 1'($urandom);
        r.lsu_wen = 1'($urandom);
        r.lsu_ren = 1'($urandom);
        r.lsu_adr = $urandom;
        r.lsu_siz = 2'($urandom);
        r.lsu_wdt = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CORES; i++) begin
            q_m[i].delete();
            cnt_m[i] = 0;
        end
        ptr_m       = 0;
        held_m      = 1'b0;
        held_core_m = 0;
    endtask

    // Called at a falling edge with inputs already driven: compare outputs
    // with the model, advance the model over the coming rising edge, then
    // return at the next falling edge.
    task automatic tick();
        bit               vld_e;
        int               core_e;
        int               idx;
        logic [CORES-1:0] rdy_e;
        bit   [CORES-1:0] acc;
        vld_e  = 1'b0;
        core_e = 0;
        if (held_m) begin
            vld_e  = 1'b1;
            core_e = held_core_m;
        end else begin
            for (int k = 0; k < CORES; k++) begin
                idx = (ptr_m + k) % CORES;
                if (!vld_e && q_m[idx].size() > 0) begin
                    vld_e  = 1'b1;
                    core_e = idx;
                end
            end
        end
        for (int i = 0; i < CORES; i++) rdy_e[i] = (q_m[i].size() < DEPTH);
        check_eq("in_rdy", in_rdy, rdy_e);
        check_eq("out_vld", out_vld, vld_e);
        if (vld_e) begin
            check_eq("out_core", out_core, core_e);
            check_eq("out_rec", out_rec, q_m[core_e][0]);
        end
        if (out_vld && out_rdy) begin
            log_adr.push_back(out_rec.ifu_adr);
            log_core.push_back(int'(out_core));
        end
        for (int i = 0; i < CORES; i++) acc[i] = in_vld[i] && (q_m[i].size() < DEPTH);
        if (vld_e && out_rdy) begin
            q_m[core_e].delete(0);
            ptr_m  = (core_e + 1) % CORES;
            held_m = 1'b0;
            cnt_m[core_e]++;
        end else if (vld_e) begin
            held_m      = 1'b1;
            held_core_m = core_e;
        end
        for (int i = 0; i < CORES; i++) if (acc[i]) q_m[i].push_back(in_rec[i]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle(input logic rdy);
        in_vld  = '0;
        out_rdy = rdy;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        check_eq({tag, "_vld"}, out_vld, 1'b0);
        check_eq({tag, "_rdy"}, in_rdy, {CORES{1'b1}});
        check_eq({tag, "_core"}, out_core, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    trace_rec_t r0;

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        in_vld  = '0;
        in_rec  = '0;
        out_rdy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_vld", out_vld, 1'b0);
        check_eq("rst_core", out_core, '0);
        check_eq("rst_rec", out_rec, '0);
        check_eq("rst_rdy", in_rdy, {CORES{1'b1}});
`ifdef TRACE_ARB_STAT_EN
        check_eq("rst_cnt", cnt, '0);
`endif
        rst = 1'b1;
        @(negedge clk);

        // Single hart, three consecutive records
        log_adr.delete();
        for (int j = 0; j < 3; j++) begin
            in_vld            = 2'b01;
            in_rec[0]         = rnd_rec();
            in_rec[0].ifu_adr = 32'h8000_0000 + 32'(4 * j);
            in_rec[1]         = rnd_rec();
            out_rdy           = 1'b1;
            tick();
            if (j == 0) check_eq("s1_latency", out_vld, 1'b1);
        end
        drive_idle(1'b1);
        repeat (4) tick();
        check_eq("s1_count", log_adr.size(), 3);
        for (int j = 0; j < 3 && j < log_adr.size(); j++)
            check_eq("s1_order", log_adr[j], 32'h8000_0000 + 32'(4 * j));

        // Two harts pushing continuously: alternation, no bubble
        log_core.delete();
        for (int j = 0; j < 8; j++) begin
            in_vld    = 2'b11;
            in_rec[0] = rnd_rec();
            in_rec[1] = rnd_rec();
            out_rdy   = 1'b1;
            tick();
        end
        check_eq("s2_xfers", log_core.size(), 7);
        for (int j = 1; j < log_core.size(); j++)
            check_eq("s2_alt", log_core[j] ^ log_core[j-1], 1);
        drive_idle(1'b1);
        repeat (12) tick();

        // Backpressure: grant held on hart 0 while hart 1 pushes
        r0        = rnd_rec();
        in_vld    = 2'b01;
        in_rec[0] = r0;
        out_rdy   = 1'b0;
        tick();
        for (int j = 0; j < 5; j++) begin
            in_vld    = 2'b10;
            in_rec[1] = rnd_rec();
            out_rdy   = 1'b0;
            check_eq("s3_vld", out_vld, 1'b1);
            check_eq("s3_core", out_core, 1'b0);
            check_eq("s3_rec", out_rec, r0);
            tick();
        end
        check_eq("s3_core_rel", out_core, 1'b0);
        drive_idle(1'b1);
        repeat (8) tick();

        // Full FIFO: only the first four of six pushes are accepted
        log_adr.delete();
        for (int j = 1; j <= 6; j++) begin
            in_vld            = 2'b01;
            in_rec[0]         = rnd_rec();
            in_rec[0].ifu_adr = 32'(j);
            out_rdy           = 1'b0;
            tick();
            if (j == 4) check_eq("s4_full", in_rdy[0], 1'b0);
        end
        in_vld            = 2'b01;
        in_rec[0].ifu_adr = 32'd7;
        out_rdy           = 1'b1;
        tick();
        drive_idle(1'b1);
        repeat (8) tick();
        check_eq("s4_count", log_adr.size(), 4);
        for (int j = 0; j < 4 && j < log_adr.size(); j++)
            check_eq("s4_rec", log_adr[j], 32'(j + 1));

        // Reset with records queued
        for (int j = 0; j < 3; j++) begin
            in_vld    = 2'b01;
            in_rec[0] = rnd_rec();
            out_rdy   = 1'b0;
            tick();
        end
        drive_idle(1'b0);
        do_reset("s5_rst");
        log_adr.delete();
        for (int j = 0; j < 2; j++) begin
            in_vld            = 2'b10;
            in_rec[1]         = rnd_rec();
            in_rec[1].ifu_adr = 32'h100 + 32'(4 * j);
            out_rdy           = 1'b1;
            tick();
        end
        drive_idle(1'b1);
        repeat (4) tick();
        check_eq("s5_count", log_adr.size(), 2);
        for (int j = 0; j < 2 && j < log_adr.size(); j++)
            check_eq("s5_rec", log_adr[j], 32'h100 + 32'(4 * j));

`ifdef TRACE_ARB_STAT_EN
        // Statistics: 3 records from hart 0, 7 from hart 1
        begin
            int need0;
            int need1;
            drive_idle(1'b0);
            do_reset("s6_rst");
            need0 = 3;
            need1 = 7;
            for (int j = 0; j < 40 && (need0 > 0 || need1 > 0); j++) begin
                in_vld[0] = (need0 > 0) && in_rdy[0];
                in_vld[1] = (need1 > 0) && in_rdy[1];
                in_rec[0] = rnd_rec();
                in_rec[1] = rnd_rec();
                out_rdy   = 1'b1;
                if (in_vld[0]) need0--;
                if (in_vld[1]) need1--;
                tick();
            end
            drive_idle(1'b1);
            repeat (12) tick();
            check_eq("s6_cnt0", cnt[0], 64'd3);
            check_eq("s6_cnt1", cnt[1], 64'd7);
        end
`endif

        // Randomized traffic
        for (int j = 0; j < 400; j++) begin
            in_vld    = 2'($urandom);
            in_rec[0] = rnd_rec();
            in_rec[1] = rnd_rec();
            out_rdy   = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive_idle(1'b1);
        repeat (12) tick();
        check_eq("end_idle", out_vld, 1'b0);
`ifdef TRACE_ARB_STAT_EN
        for (int i = 0; i < CORES; i++) check_eq("end_cnt", cnt[i], cnt_m[i]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
